// File: rtl/cnt_pkg.sv
// Shared constants and helpers for the counter/timer library.
package cnt_pkg;

    localparam logic CNT_UP   = 1'b0;
    localparam logic CNT_DN   = 1'b1;
    localparam logic CNT_WRAP = 1'b0;
    localparam logic CNT_SAT  = 1'b1;

    // Smallest width able to hold 0..modulus-1; a modulus of 2 still needs one bit.
    function automatic int cnt_width(input int modulus);
        return (modulus <= 2) ? 1 : $clog2(modulus);
    endfunction

endpackage

// File: rtl/mod_n_next.sv
// Combinational next-count step for a modulo-N counter.
// Computes the stepped value, whether the count sits at the limit for the
// chosen direction, and whether this step would wrap around.
module mod_n_next
    import cnt_pkg::*;
#(
    parameter int MODULUS = 5,
    parameter int WIDTH   = cnt_width(MODULUS)
) (
    input  logic [WIDTH-1:0] count,
    input  logic             dir,
    input  logic             mode,
    output logic [WIDTH-1:0] next_count,
    output logic             at_limit,
    output logic             wrap_evt
);

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);

    // Step one position in the chosen direction, never leaving 0..MODULUS-1.
    always_comb begin
        next_count = count;
        at_limit   = 1'b0;
        wrap_evt   = 1'b0;
        if (dir == CNT_UP) begin
            at_limit = (count == MAX_VAL);
            if (!at_limit) begin
                next_count = count + WIDTH'(1);
            end else if (mode == CNT_WRAP) begin
                next_count = '0;
                wrap_evt   = 1'b1;
            end
        end else begin
            at_limit = (count == '0);
            if (!at_limit) begin
                next_count = count - WIDTH'(1);
            end else if (mode == CNT_WRAP) begin
                next_count = MAX_VAL;
                wrap_evt   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mod_n_up_down_counter.sv
// Parametrised modulo-N up/down counter with clamped parallel load,
// per-cycle wrap/saturate selection, combinational terminal count for
// cascading, and registered wrap / load-clamp pulses.
module mod_n_up_down_counter
    import cnt_pkg::*;
#(
    parameter int MODULUS = 5,
    parameter int WIDTH   = cnt_width(MODULUS),
    parameter int RST_VAL = 0
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_en,
    input  logic             i_up_down,
    input  logic             i_sat,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    output logic [WIDTH-1:0] o_Q,
    output logic             o_tc,
    output logic             o_wrap,
    output logic             o_load_err
);

    // Parameter sanity: reject configurations the counter cannot represent.
    if (MODULUS < 2) begin : g_bad_modulus
        $error("mod_n_up_down_counter: MODULUS must be >= 2");
    end
    if ((2 ** WIDTH) < MODULUS) begin : g_bad_width
        $error("mod_n_up_down_counter: WIDTH too small for MODULUS");
    end
    if ((RST_VAL < 0) || (RST_VAL >= MODULUS)) begin : g_bad_rst_val
        $error("mod_n_up_down_counter: RST_VAL must be in 0..MODULUS-1");
    end

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
    // One bit wider so the range check stays meaningful when MODULUS is a power of two.
    localparam logic [WIDTH:0]   MAX_EXT = (WIDTH + 1)'(MODULUS - 1);
    localparam logic [WIDTH-1:0] RST_Q   = WIDTH'(RST_VAL);

    logic [WIDTH-1:0] step_val;
    logic             at_limit;
    logic             wrap_evt;
    logic             load_oob;
    logic [WIDTH-1:0] load_q;

    mod_n_next #(
        .MODULUS (MODULUS),
        .WIDTH   (WIDTH)
    ) u_next (
        .count      (o_Q),
        .dir        (i_up_down),
        .mode       (i_sat),
        .next_count (step_val),
        .at_limit   (at_limit),
        .wrap_evt   (wrap_evt)
    );

    // Clamp out-of-range load values to the top of the count range.
    always_comb begin
        load_oob = ({1'b0, i_load_val} > MAX_EXT);
        load_q   = load_oob ? MAX_VAL : i_load_val;
    end

    // Terminal count: the next edge will wrap in the current direction.
    always_comb begin
        o_tc = i_en & ~i_load & ~i_sat & at_limit;
    end

    // Count register and event pulses; load beats enable, enable beats hold.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_Q        <= RST_Q;
            o_wrap     <= 1'b0;
            o_load_err <= 1'b0;
        end else if (i_load) begin
            o_Q        <= load_q;
            o_wrap     <= 1'b0;
            o_load_err <= load_oob;
        end else if (i_en) begin
            o_Q        <= step_val;
            o_wrap     <= wrap_evt;
            o_load_err <= 1'b0;
        end else begin
            o_wrap     <= 1'b0;
            o_load_err <= 1'b0;
        end
    end

endmodule

// File: doc/mod_n_up_down_counter.md
Name: mod_n_up_down_counter

Overview:
Parametrised modulo-N up/down counter. Generalises the fixed mod-5 counter with:
- a configurable modulus,
- a synchronous parallel load with out-of-range clamping,
- a per-cycle choice of wrap or saturate at the limits,
- a combinational terminal-count output for cascading into a higher-order stage,
- a registered wrap pulse for event logging.

It sits in the counter/timer library. Several instances can chain via o_tc → i_en of the next stage.

Parameters:
- MODULUS, 5, count range 0..MODULUS-1; legal values >= 2.
- WIDTH, $clog2(MODULUS), width of count and load value; an override must satisfy 2**WIDTH >= MODULUS.
- RST_VAL, 0, count value on reset; must be < MODULUS. Elaboration error otherwise.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_en  in  1  count enable.
- i_up_down  in  1  0 = count up, 1 = count down.
- i_sat  in  1  0 = wrap at limits, 1 = saturate at limits.
- i_load  in  1  synchronous load strobe.
- i_load_val  in  WIDTH  value to load.
- o_Q  out  WIDTH  current count, registered.
- o_tc  out  1  terminal count, combinational, for cascading.
- o_wrap  out  1  registered one-cycle pulse, wrap occurred on the previous edge.
- o_load_err  out  1  registered one-cycle pulse, last load was clamped.

Behaviour:
- Reset: i_rst_n low asynchronously forces o_Q=RST_VAL, o_wrap=0, o_load_err=0. Outputs hold while low. Release is synchronised externally; the block adds no extra reset latency.
- Priority per rising edge: i_load > i_en > hold.
- Load:
  - o_Q <= i_load_val if i_load_val < MODULUS.
  - Otherwise o_Q <= MODULUS-1 and o_load_err <= 1.
  - Load ignores i_en, i_up_down and i_sat, and never asserts o_wrap.
- Count (i_en=1, i_load=0):
  - Up: o_Q < MODULUS-1 → o_Q+1.
  - Up at MODULUS-1: i_sat=0 → 0 with o_wrap <= 1; i_sat=1 → hold MODULUS-1, o_wrap stays 0.
  - Down: o_Q > 0 → o_Q-1.
  - Down at 0: i_sat=0 → MODULUS-1 with o_wrap <= 1; i_sat=1 → hold 0.
- Hold (i_en=0, i_load=0): o_Q unchanged, o_wrap <= 0, o_load_err <= 0.
- o_wrap and o_load_err are pulses: each is cleared on any edge where its condition does not recur.
- o_tc = i_en & ~i_load & ~i_sat & at-limit for the current direction (o_Q==MODULUS-1 when up, o_Q==0 when down).
  - Purely combinational, same cycle as the inputs.
  - o_tc high means a wrap happens on the next edge.
- Direction change takes effect on the same edge as the new i_up_down; there is no turnaround cycle.
- Latency: one clock from input to o_Q. o_wrap and o_load_err align with the o_Q update that caused them.
- Arithmetic: no intermediate values outside 0..MODULUS-1. Limit comparisons use the constant MODULUS-1 at WIDTH bits.
- Power-of-two MODULUS: wrap behaviour is identical to the non-power-of-two case. No reliance on natural overflow.
- Reset asserted mid-count: immediate return to RST_VAL and flags cleared, regardless of pending load or enable.

Decomposition:
- Shared package cnt_pkg:
  - direction constants CNT_UP=1'b0 and CNT_DN=1'b1;
  - limit-mode constants CNT_WRAP=1'b0 and CNT_SAT=1'b1;
  - a function computing the default width from the modulus.
- Sub-module mod_n_next (combinational):
  - inputs: o_Q, direction, mode;
  - outputs: next count, at-limit, wrap-event.
  - It is reused by a later multi-channel timer.
- The top level holds the registers, load clamping and priority mux.

Test Plan (MODULUS=5, RST_VAL=0 unless stated):
1. Reset low for 2 cycles, release, i_en=1, up, wrap → o_Q 0,1,2,3,4,0. o_tc=1 only while o_Q=4. o_wrap=1 for exactly the cycle o_Q=0 after 4.
2. From o_Q=2, down, wrap → 1,0,4,3. o_tc high while o_Q=0. o_wrap pulses with o_Q=4.
3. Saturate: i_sat=1, up from 3 → 4,4,4 with o_wrap=0 and o_tc=0. Then down from 1 → 0,0.
4. Load: i_load=1, i_load_val=3 with i_en=1 → o_Q=3, o_load_err=0. Then i_load_val=7 → o_Q=4, o_load_err=1 for one cycle. Simultaneous load and count: load wins.
5. Hold and direction flip: i_en=0 for 3 cycles at o_Q=2 → o_Q stays 2. Toggle i_up_down every cycle with i_en=1 → 3,2,3,2.
6. Async reset mid-operation: assert i_rst_n=0 between edges while o_Q=3 → o_Q=0 immediately, before the next edge. Repeat with MODULUS=8 and RST_VAL=6 → reset to 6, up wraps 7→0.
